fsb_tx_feeder: RTL and testbench

//  Byte queue and sequencer upstream of the fast serial bus transmitter.
//  - Host pushes bytes with a valid/ready handshake; they are buffered in a DEPTH-entry FIFO.
//  - Bytes are handed one at a time to the transmitter over tDP/tEN/tDONE.
//  - Drives the transmitter's bit period (cycle) and enforces an inter-byte gap.

---
 rtl/fsb_tx_feeder.sv | 146 ++++++++++++++
 tb/tb_fsb_tx_feeder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsb_tx_feeder.sv
// Byte FIFO and sequencer feeding the fast serial bus transmitter over tDP/tEN/tDONE.
// Optional transmit watchdog is compiled in when FSB_TX_TIMEOUT_EN is defined.
module fsb_tx_feeder #(
    parameter int          DEPTH   = 8,
    parameter logic [15:0] CYCLE   = 16'd8,
    parameter int          GAP     = 4,
    parameter int          TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             wrData,
    input  logic                   wrValid,
    output logic                   wrReady,
    output logic [7:0]             tDP,
    output logic                   tEN,
    input  logic                   tDONE,
    output logic [15:0]            cycle,
    output logic [$clog2(DEPTH):0] level,
    output logic                   idle,
    output logic                   txErr
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STROBE, S_WAIT, S_GAP} state_t;
    typedef logic [WW-1:0] wd_t;

    // With GAP=0 the gap state is never entered.
    localparam state_t AFTER_BYTE = (GAP > 0) ? S_GAP : S_IDLE;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_next;
    logic          push;
    logic          pop;
    logic [GW-1:0] gap_cnt;

    assign cycle = CYCLE;

    always_comb begin
        push       = wrValid && wrReady;
        pop        = (state == S_LOAD);
        level_next = level + LW'(push) - LW'(pop);
    end

    // NOTE: the storage array has no reset; level and the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wrData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            wrReady <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level   <= level_next;
            wrReady <= (level_next != LW'(DEPTH));
        end
    end

`ifdef FSB_TX_TIMEOUT_EN
    wd_t wd_cnt;
`else
    assign txErr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tDP     <= '0;
            tEN     <= 1'b0;
            idle    <= 1'b1;
            gap_cnt <= '0;
`ifdef FSB_TX_TIMEOUT_EN
            wd_cnt  <= '0;
            txErr   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (level != '0) begin
                        state <= S_LOAD;
                        idle  <= 1'b0;
                    end else begin
                        idle <= (level_next == '0);
                    end
                end
                S_LOAD: begin
                    tDP   <= mem[rd_ptr];
                    tEN   <= 1'b0;
                    idle  <= 1'b0;
                    state <= S_STROBE;
`ifdef FSB_TX_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                S_STROBE: begin
                    // Hold tEN for at least one cycle, then release once the transmitter has armed.
                    if (!tEN) begin
                        tEN <= 1'b1;
                    end else if (!tDONE) begin
                        tEN   <= 1'b0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tDONE) begin
                        state   <= AFTER_BYTE;
                        gap_cnt <= '0;
                        idle    <= (AFTER_BYTE == S_IDLE) && (level_next == '0);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(GAP - 1)) begin
                        state <= S_IDLE;
                        idle  <= (level_next == '0);
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef FSB_TX_TIMEOUT_EN
            if (state == S_STROBE || state == S_WAIT) begin
                if (wd_cnt == wd_t'(TIMEOUT - 1)) begin
                    tEN     <= 1'b0;
                    txErr   <= 1'b1;
                    state   <= AFTER_BYTE;
                    gap_cnt <= '0;
                    idle    <= (AFTER_BYTE == S_IDLE) && (level_next == '0);
                end else begin
                    wd_cnt <= wd_cnt + wd_t'(1);
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_fsb_tx_feeder.sv
// Self-checking bench for fsb_tx_feeder: transmitter model, byte-order scoreboard and
// directed/random push stimulus. Timeout checks follow FSB_TX_TIMEOUT_EN.
module tb_fsb_tx_feeder;
    localparam int DEPTH = 8;
    localparam int CYC   = 8;
    localparam int GAP   = 4;
    localparam int TOUT  = 64;

    logic        clk;
    logic        rst_n;
    logic [7:0]  wrData;
    logic        wrValid;
    logic        wrReady;
    logic [7:0]  tDP;
    logic        tEN;
    logic        tDONE;
    logic [15:0] cycle;
    logic [3:0]  level;
    logic        idle;
    logic        txErr;

    fsb_tx_feeder #(
        .DEPTH(DEPTH), .CYCLE(16'(CYC)), .GAP(GAP), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
        .tDP(tDP), .tEN(tEN), .tDONE(tDONE), .cycle(cycle), .level(level),
        .idle(idle), .txErr(txErr)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         pulses   = 0;
    int         acc_total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] held;
    bit         in_flight;
    bit         ten_prev;
    bit         done_prev;
    bit         tx_hang;
    int         tx_cnt;
    logic       ten_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter: arms (tDONE=0) on the edge after tEN rises, finishes 10*CYCLE cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tDONE  <= 1'b1;
            tx_cnt <= 0;
            ten_q  <= 1'b0;
        end else begin
            ten_q <= tEN;
            if (tEN && !ten_q) begin
                tDONE  <= 1'b0;
                tx_cnt <= 10 * CYC;
            end else if (!tDONE && !tx_hang) begin
                if (tx_cnt <= 1) tDONE <= 1'b1;
                else             tx_cnt <= tx_cnt - 1;
            end
        end
    end

    // Scoreboard: every tEN rise must present the oldest accepted byte, held until tDONE returns.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ten_prev  = 1'b0;
                done_prev = 1'b1;
                in_flight = 1'b0;
            end else begin
                if (tEN && !ten_prev) begin
                    pulses++;
                    if (exp_q.size() == 0) check("spurious_ten", exp_q.size(), 1);
                    else                   check("tdp_order", 32'(tDP), 32'(exp_q.pop_front()));
                    held      = tDP;
                    in_flight = 1'b1;
                end
                if (tDONE && !done_prev && in_flight) begin
                    check("tdp_stable", 32'(tDP), 32'(held));
                    in_flight = 1'b0;
                end
                ten_prev  = tEN;
                done_prev = tDONE;
            end
        end
    end

    // Called #1 after an edge; returns #1 after the edge at which the push is offered.
    task automatic drive_push(input logic [7:0] d, output bit acc);
        wrValid = 1'b1;
        wrData  = d;
        acc     = wrReady;
        if (acc) begin
            exp_q.push_back(d);
            acc_total++;
        end
        @(posedge clk); #1;
        wrValid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(idle), 1);
    endtask

    task automatic wait_tdone(input logic v, input string tag, input int budget);
        int n;
        n = 0;
        while (tDONE !== v && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(tDONE), 32'(v));
    endtask

    initial begin
        bit acc;
        int n;
        int snap_p;
        int snap_a;
        logic [7:0] d;

        rst_n   = 1'b0;
        wrValid = 1'b0;
        wrData  = 8'h00;
        tx_hang = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_level", 32'(level), 0);
        check("rst_wrready", 32'(wrReady), 1);
        check("rst_tdp", 32'(tDP), 0);
        check("rst_ten", 32'(tEN), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_txerr", 32'(txErr), 0);
        check("cycle_port", 32'(cycle), CYC);

        // T1: single byte latency and return to idle
        drive_push(8'hA5, acc);
        check("t1_ten_n", 32'(tEN), 0);
        @(posedge clk); #1;
        check("t1_ten_n1", 32'(tEN), 0);
        @(posedge clk); #1;
        check("t1_tdp_n2", 32'(tDP), 32'h A5);
        check("t1_ten_n2", 32'(tEN), 0);
        @(posedge clk); #1;
        check("t1_ten_n3", 32'(tEN), 1);
        wait_tdone(1'b0, "t1_armed", 20);
        wait_tdone(1'b1, "t1_done", 200);
        // tDONE is seen by the sequencer one edge later, then GAP cycles pass.
        n = 0;
        while (idle !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("t1_done_to_idle", n, GAP + 1);
        check("t1_pulses", pulses, 1);

        // T2: fill the FIFO while the first byte is in flight
        snap_p = pulses;
        d = 8'h01;
        n = 0;
        acc = 1'b1;
        while (acc && n < 20) begin
            drive_push(d, acc);
            if (acc) d = d + 8'h01;
            n++;
        end
        check("t2_accepted", 32'(d - 8'h01), DEPTH + 1);
        check("t2_level_full", 32'(level), DEPTH);
        check("t2_wrready_full", 32'(wrReady), 0);
        drive_push(8'hEE, acc);
        check("t2_push_refused", 32'(acc), 0);
        wait_idle("t2_drain", 1500);
        check("t2_pulses", pulses - snap_p, DEPTH + 1);
        check("t2_queue_empty", exp_q.size(), 0);

        // T3: simultaneous push and pop at level 3, then at level DEPTH
        repeat (4) drive_push(8'($urandom), acc);
        wait_tdone(1'b0, "t3_armed", 20);
        check("t3_level3", 32'(level), 3);
        wait_tdone(1'b1, "t3_done", 200);
        // The pop lands GAP+3 edges after tDONE: WAIT sample, GAP cycles, IDLE, LOAD.
        repeat (GAP + 2) @(posedge clk);
        #1;
        drive_push(8'($urandom), acc);
        check("t3_level_pushpop", 32'(level), 3);
        wait_tdone(1'b0, "t3_armed2", 20);
        repeat (5) drive_push(8'($urandom), acc);
        check("t3_level_full", 32'(level), DEPTH);
        check("t3_wrready_full", 32'(wrReady), 0);
        wait_tdone(1'b1, "t3_done2", 200);
        repeat (GAP + 2) @(posedge clk);
        #1;
        drive_push(8'($urandom), acc);
        check("t3_full_pop_refused", 32'(acc), 0);
        check("t3_level_after_pop", 32'(level), DEPTH - 1);
        check("t3_wrready_after_pop", 32'(wrReady), 1);
        wait_idle("t3_drain", 1500);

        // T4: reset during WAIT with 4 bytes queued
        repeat (5) drive_push(8'($urandom), acc);
        wait_tdone(1'b0, "t4_armed", 20);
        repeat (3) @(posedge clk);
        #1;
        check("t4_level4", 32'(level), 4);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t4_ten", 32'(tEN), 0);
        check("t4_level", 32'(level), 0);
        check("t4_tdp", 32'(tDP), 0);
        check("t4_wrready", 32'(wrReady), 1);
        check("t4_idle", 32'(idle), 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap_p = pulses;
        repeat (200) @(posedge clk);
        #1;
        check("t4_no_ten_after_reset", pulses - snap_p, 0);
        drive_push(8'($urandom), acc);
        wait_idle("t4_new_byte", 300);
        check("t4_new_pulse", pulses - snap_p, 1);

        // T5/T6: transmitter never completes
        snap_p  = pulses;
        tx_hang = 1'b1;
        drive_push(8'($urandom), acc);
        drive_push(8'($urandom), acc);
`ifdef FSB_TX_TIMEOUT_EN
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_ten_up", 32'(tEN), 1);
        repeat (62) @(posedge clk);
        #1;
        check("t5_no_err_yet", 32'(txErr), 0);
        @(posedge clk); #1;
        check("t5_err", 32'(txErr), 1);
        check("t5_ten_dropped", 32'(tEN), 0);
        check("t5_level", 32'(level), exp_q.size());
        tx_hang = 1'b0;
        wait_idle("t5_next_byte", 400);
        check("t5_err_sticky", 32'(txErr), 1);
        check("t5_pulses", pulses - snap_p, 2);
`else
        repeat (300) @(posedge clk);
        #1;
        check("t6_txerr", 32'(txErr), 0);
        check("t6_level", 32'(level), 1);
        check("t6_ten", 32'(tEN), 0);
        check("t6_not_idle", 32'(idle), 0);
        tx_hang = 1'b0;
        wait_idle("t6_resume", 400);
        check("t6_pulses", pulses - snap_p, 2);
`endif

        // T7: random push traffic, order and count checked by the scoreboard
        snap_p = pulses;
        snap_a = acc_total;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) drive_push(8'($urandom), acc);
            else begin
                @(posedge clk); #1;
            end
        end
        wait_idle("t7_drain", 1500);
        check("t7_pulses", pulses - snap_p, acc_total - snap_a);
        check("t7_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
